otg_access: RTL and testbench

Hardware sequencer for the OTG host-controller parallel bus in the USB subsystem. It replaces bit-banging of OTG_CS_N/OTG_RD_N/OTG_WR_N/OTG_RST_N through individual out_ports. The USB controller CPU issues one register read, register write or chip reset through a command/response toggle handshake, and this block generates the bus cycle with programmable setup, strobe and hold timing. It sits between the USB CPU's port space and the OTG pins.

---
 rtl/otg_access_pkg.sv | 33 +++
 rtl/otg_access_if.sv | 26 ++
 rtl/otg_phase_timer.sv | 35 +++
 rtl/otg_access.sv | 174 +++++++++++++++++
 tb/tb_otg_access.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/otg_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otg_access_pkg
//  Description : Shared types and helpers for the OTG parallel-bus sequencer
//  Revision    : 1.0  initial release
// ============================================================================
package otg_access_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RST     = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RESET = 2'd2;

  // Largest of the four phase lengths, used to size the phase counter
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otg_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : otg_access_if
//  Description : CPU command/response toggle handshake bundle
//  Revision    : 1.0  initial release
// ============================================================================
interface otg_access_if;
  logic        command;
  logic        response;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] rdata;
  logic        busy;

  modport master (
    output command, cmd_op, cmd_addr, cmd_wdata,
    input  response, rdata, busy
  );

  modport slave (
    input  command, cmd_op, cmd_addr, cmd_wdata,
    output response, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/otg_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : otg_phase_timer
//  Description : Loadable down-counter with zero flag, frozen when en is low
//  Revision    : 1.0  initial release
// ============================================================================
module otg_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Load takes priority over counting; the count parks at zero
  always_ff @(posedge clk) begin
    if (en) begin
      if (rst)
        r_count <= '0;
      else if (load)
        r_count <= load_val;
      else if (r_count != '0)
        r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/otg_access.sv
`default_nettype none
// ============================================================================
//  Module      : otg_access
//  Description : OTG host-controller bus sequencer (read/write/chip reset)
//                driven by a CPU command/response toggle handshake
//  Revision    : 1.0  initial release
// ============================================================================
module otg_access
  import otg_access_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int RESET_CYCLES  = 1000
) (
  input  logic               clock,
  input  logic               clock_valid,
  input  logic               reset,
  otg_access_if.slave        bus,
  output logic [1:0]         OTG_ADDR,
  inout  wire  [15:0]        OTG_DATA,
  output logic               OTG_CS_N,
  output logic               OTG_RD_N,
  output logic               OTG_WR_N,
  output logic               OTG_RST_N
);

  localparam int CW = $clog2(max4(SETUP_CYCLES, STROBE_CYCLES,
                                  HOLD_CYCLES, RESET_CYCLES)) + 1;

  localparam logic [CW-1:0] C_SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_RESET_LD  = CW'(RESET_CYCLES - 1);

  state_t       r_state;
  logic [1:0]   r_op;
  logic [15:0]  r_wdata;
  logic [15:0]  r_rdata;
  logic         r_response;

  logic         w_pending;
  logic         w_load;
  logic [CW-1:0] w_load_val;
  logic         w_zero;
  logic         w_data_oe;

  assign w_pending = (bus.command != r_response);

  // Phase-entry load value for the timer; phases end when it reaches zero
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        if (w_pending) begin
          w_load     = 1'b1;
          w_load_val = (bus.cmd_op == OP_RESET) ? C_RESET_LD : C_SETUP_LD;
        end
      end
      SETUP: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = C_STROBE_LD;
        end
      end
      STROBE: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = C_HOLD_LD;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  otg_phase_timer #(.WIDTH(CW)) u_timer (
    .clk      (clock),
    .rst      (reset),
    .en       (clock_valid),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  // Bus-cycle sequencer with registered pin outputs
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        r_state    <= IDLE;
        r_op       <= OP_READ;
        r_wdata    <= '0;
        r_rdata    <= '0;
        r_response <= 1'b0;
        OTG_ADDR   <= '0;
        OTG_CS_N   <= 1'b1;
        OTG_RD_N   <= 1'b1;
        OTG_WR_N   <= 1'b1;
        OTG_RST_N  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pending) begin
              r_op    <= bus.cmd_op;
              r_wdata <= bus.cmd_wdata;
              case (bus.cmd_op)
                OP_READ, OP_WRITE: begin
                  r_state  <= SETUP;
                  OTG_ADDR <= bus.cmd_addr;
                  OTG_CS_N <= 1'b0;
                end
                OP_RESET: begin
                  r_state   <= RST;
                  OTG_RST_N <= 1'b0;
                end
                default: begin
                  r_state    <= RECOVER;
                  r_response <= ~r_response;
                end
              endcase
            end
          end
          SETUP: begin
            if (w_zero) begin
              r_state <= STROBE;
              if (r_op == OP_WRITE) OTG_WR_N <= 1'b0;
              else                  OTG_RD_N <= 1'b0;
            end
          end
          STROBE: begin
            if (w_zero) begin
              r_state  <= HOLD;
              OTG_RD_N <= 1'b1;
              OTG_WR_N <= 1'b1;
              // Sample on the edge where RD_N rises
              if (r_op == OP_READ) r_rdata <= OTG_DATA;
            end
          end
          HOLD: begin
            if (w_zero) begin
              r_state    <= RECOVER;
              OTG_CS_N   <= 1'b1;
              r_response <= ~r_response;
            end
          end
          RST: begin
            if (w_zero) begin
              r_state    <= RECOVER;
              OTG_RST_N  <= 1'b1;
              r_response <= ~r_response;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Data pins are driven only while a write cycle owns the bus
  assign w_data_oe = (r_op == OP_WRITE) &&
                     ((r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD));
  assign OTG_DATA  = w_data_oe ? r_wdata : 16'hzzzz;

  assign bus.response = r_response;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_otg_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otg_access
//  Description : Self-checking bench for otg_access (vector table + sequences)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_otg_access;
  import otg_access_pkg::*;

  logic        clk = 1'b0;
  logic        clock_valid;
  logic        reset;
  logic [1:0]  otg_addr;
  wire  [15:0] otg_data;
  logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n;
  logic [15:0] pin_data;

  int checks = 0;
  int errors = 0;

  otg_access_if bus ();

  otg_access #(
    .SETUP_CYCLES (2),
    .STROBE_CYCLES(4),
    .HOLD_CYCLES  (2),
    .RESET_CYCLES (5)
  ) dut (
    .clock      (clk),
    .clock_valid(clock_valid),
    .reset      (reset),
    .bus        (bus.slave),
    .OTG_ADDR   (otg_addr),
    .OTG_DATA   (otg_data),
    .OTG_CS_N   (otg_cs_n),
    .OTG_RD_N   (otg_rd_n),
    .OTG_WR_N   (otg_wr_n),
    .OTG_RST_N  (otg_rst_n)
  );

  // Chip model: returns pin_data while RD_N is low
  assign otg_data = (!otg_rd_n) ? pin_data : 16'hzzzz;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] pin;
    int          done;
    int          cs;
    int          rd;
    int          wr;
    int          rstl;
    int          first;
    int          oe;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[6];

  // Measurements from the last run_op
  int m_done, m_cs, m_rd, m_wr, m_rst, m_first, m_oe, m_addr, m_wmatch;
  logic exp_resp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one command at a negedge and profile the pins until response toggles
  task automatic run_op(input logic [1:0] op, input logic [1:0] addr,
                        input logic [15:0] wdata, input logic [15:0] pin,
                        input int fz_at, input int fz_len);
    logic prev;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    pin_data      = pin;
    prev          = bus.response;
    bus.command   = ~bus.command;
    m_done = -1; m_cs = 0; m_rd = 0; m_wr = 0; m_rst = 0;
    m_first = -1; m_oe = 0; m_addr = 0; m_wmatch = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (!otg_cs_n) begin
        m_cs++;
        if (otg_addr == addr)  m_addr++;
        if (otg_data == wdata) m_wmatch++;
      end
      if (!otg_rd_n)  m_rd++;
      if (!otg_wr_n)  m_wr++;
      if (!otg_rst_n) m_rst++;
      if ((!otg_rd_n || !otg_wr_n) && m_first < 0) m_first = cyc;
      if (dut.w_data_oe) m_oe++;
      if (fz_len > 0 && cyc == fz_at)          clock_valid = 1'b0;
      if (fz_len > 0 && cyc == fz_at + fz_len) clock_valid = 1'b1;
      if (bus.response != prev) begin
        m_done = cyc;
        break;
      end
    end
    clock_valid = 1'b1;
    exp_resp = ~exp_resp;
    check("response_toggle", int'(bus.response), int'(exp_resp));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int gap;
    int wait_n;

    //            op        addr  wdata     pin       done cs rd wr rst first oe rdata
    vecs[0] = '{OP_READ,  2'd2, 16'h0000, 16'hBEEF, 8, 8, 4, 0, 0,  2, 0, 16'hBEEF};
    vecs[1] = '{OP_WRITE, 2'd1, 16'h1234, 16'h0000, 8, 8, 0, 4, 0,  2, 8, 16'hBEEF};
    vecs[2] = '{OP_RESET, 2'd3, 16'h0000, 16'h0000, 5, 0, 0, 0, 5, -1, 0, 16'hBEEF};
    vecs[3] = '{2'd3,     2'd0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, -1, 0, 16'hBEEF};
    vecs[4] = '{OP_READ,  2'd3, 16'h0000, 16'h5A5A, 8, 8, 4, 0, 0,  2, 0, 16'h5A5A};
    vecs[5] = '{OP_WRITE, 2'd0, 16'hFFFF, 16'h0000, 8, 8, 0, 4, 0,  2, 8, 16'h5A5A};

    clock_valid   = 1'b1;
    reset         = 1'b1;
    bus.command   = 1'b0;
    bus.cmd_op    = OP_READ;
    bus.cmd_addr  = 2'd0;
    bus.cmd_wdata = 16'h0;
    pin_data      = 16'h0;
    exp_resp      = 1'b0;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_response", int'(bus.response), 0);
    check("rst_rdata",    int'(bus.rdata),    0);
    check("rst_busy",     int'(bus.busy),     0);
    check("rst_addr",     int'(otg_addr),     0);
    check("rst_strobes",  int'({otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n}), 15);
    check("rst_data_oe",  int'(dut.w_data_oe), 0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pin, 0, 0);
      check($sformatf("v%0d_done", i),   m_done,  vecs[i].done);
      check($sformatf("v%0d_cs_low", i), m_cs,    vecs[i].cs);
      check($sformatf("v%0d_addr", i),   m_addr,  vecs[i].cs);
      check($sformatf("v%0d_rd_low", i), m_rd,    vecs[i].rd);
      check($sformatf("v%0d_wr_low", i), m_wr,    vecs[i].wr);
      check($sformatf("v%0d_rst_low", i), m_rst,  vecs[i].rstl);
      check($sformatf("v%0d_strobe_start", i), m_first, vecs[i].first);
      check($sformatf("v%0d_data_oe", i), m_oe,   vecs[i].oe);
      if (vecs[i].op == OP_WRITE)
        check($sformatf("v%0d_wdata_pins", i), m_wmatch, 8);
      check($sformatf("v%0d_rdata", i), int'(bus.rdata), int'(vecs[i].rdata));
      // Completion edge leaves the block in RECOVER with the bus released
      check($sformatf("v%0d_recover_busy", i), int'(bus.busy), 1);
      check($sformatf("v%0d_recover_cs", i), int'(otg_cs_n), 1);
      idle_cycles(1);
      check($sformatf("v%0d_idle_busy", i), int'(bus.busy), 0);
      idle_cycles(2);
    end

    // Back-to-back: retoggle command on the cycle response toggles
    run_op(OP_READ, 2'd1, 16'h0, 16'hA001, 0, 0);
    check("b2b_first_rdata", int'(bus.rdata), 16'hA001);
    bus.cmd_op   = OP_READ;
    bus.cmd_addr = 2'd0;
    pin_data     = 16'h1111;
    bus.command  = ~bus.command;
    gap = 0;
    wait_n = 0;
    while (otg_cs_n && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
      if (otg_cs_n) gap++;
    end
    check("b2b_cs_reasserted", int'(otg_cs_n), 0);
    check("b2b_gap_ge1", int'(gap >= 1), 1);
    wait_n = 0;
    while (bus.response == exp_resp && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    exp_resp = ~exp_resp;
    check("b2b_second_done", int'(bus.response), int'(exp_resp));
    check("b2b_second_rdata", int'(bus.rdata), 16'h1111);
    idle_cycles(3);

    // clock_valid low for 3 cycles during SETUP shifts the schedule by 3
    run_op(OP_READ, 2'd2, 16'h0, 16'hC0DE, 0, 3);
    check("freeze_done",         m_done,  11);
    check("freeze_strobe_start", m_first, 5);
    check("freeze_rd_low",       m_rd,    4);
    check("freeze_cs_low",       m_cs,    11);
    check("freeze_rdata", int'(bus.rdata), 16'hC0DE);
    idle_cycles(3);

    // Synchronous reset during the strobe of a write aborts it
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = 2'd1;
    bus.cmd_wdata = 16'h55AA;
    bus.command   = ~bus.command;
    idle_cycles(3);
    check("abort_wr_low_before", int'(otg_wr_n), 0);
    reset       = 1'b1;
    bus.command = 1'b0;
    @(negedge clk);
    check("abort_cs_n",     int'(otg_cs_n), 1);
    check("abort_wr_n",     int'(otg_wr_n), 1);
    check("abort_data_oe",  int'(dut.w_data_oe), 0);
    check("abort_response", int'(bus.response), 0);
    check("abort_busy",     int'(bus.busy), 0);
    check("abort_rdata",    int'(bus.rdata), 0);
    reset    = 1'b0;
    exp_resp = 1'b0;
    idle_cycles(4);
    check("abort_no_toggle", int'(bus.response), 0);
    check("abort_stays_idle", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
